// File: rtl/crc_pkg.sv
// Shared types and CRC arithmetic helpers for the streaming CRC engine.
package crc_pkg;

    localparam int unsigned MAX_CRC_W = 32;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    // Bit-reverse one byte (bit0 becomes bit7).
    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        r = {<<{b}};
        return r;
    endfunction

    // Fold one byte MSB-first into a normal-form register of 'width' bits.
    // The register lives in the low 'width' bits of a 32-bit word.
    function automatic logic [MAX_CRC_W-1:0] crc_byte_step(
        input logic [MAX_CRC_W-1:0] crc,
        input logic [7:0]           data,
        input logic [MAX_CRC_W-1:0] poly,
        input int unsigned          width
    );
        logic [MAX_CRC_W-1:0] c;
        logic [MAX_CRC_W-1:0] top;
        logic [MAX_CRC_W-1:0] mask;
        mask = (width >= MAX_CRC_W) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        top  = 32'd1 << (width - 32'd1);
        c    = (crc ^ (32'(data) << (width - 32'd8))) & mask;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((c & top) != 32'd0) begin
                c = ((c << 1) ^ poly) & mask;
            end else begin
                c = (c << 1) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_lane_chain.sv
// Combinational chain folding 0..DATA_BYTES lanes of a beat into the CRC register.
module crc_lane_chain
    import crc_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CRC_W      = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter bit          REFLECT_IN = 1'b1,
    parameter int unsigned CNT_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic [CRC_W-1:0]        crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [CNT_W-1:0]        count,
    output logic [CRC_W-1:0]        crc_c
);

    logic [CRC_W-1:0] stage [DATA_BYTES+1];
    logic [CRC_W-1:0] pick  [DATA_BYTES+1];

    assign stage[0] = crc_in;
    assign pick[0]  = crc_in;

    // Lane g is folded after lanes 0..g-1; pick selects the stage matching count.
    for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
        logic [7:0] lane_byte;
        assign lane_byte    = REFLECT_IN ? reflect8(data[8*g +: 8]) : data[8*g +: 8];
        assign stage[g+1]   = CRC_W'(crc_byte_step(32'(stage[g]), lane_byte, POLY, CRC_W));
        assign pick[g+1]    = (count == CNT_W'(g + 1)) ? stage[g+1] : pick[g];
    end

    assign crc_c = pick[DATA_BYTES];

endmodule

// File: rtl/crc_stream.sv
// Multi-byte streaming CRC engine with held result and residue check.
module crc_stream
    import crc_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = 4,
    parameter int unsigned CRC_W       = 32,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter logic [31:0] RESIDUE     = 32'hC704DD7B
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_sof,
    input  logic                    s_eof,
    output logic [CRC_W-1:0]        crc_out,
    output logic                    crc_ok,
    output logic                    crc_valid,
    input  logic                    crc_ready,
    output logic                    err_pulse
);

    localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);

    state_t                 state;
    logic [CRC_W-1:0]       crc_reg;
    logic                   accept;
    logic [DATA_BYTES-1:0]  keep_shift;
    logic                   keep_run;
    logic                   keep_gap;
    logic [CNT_W-1:0]       keep_cnt;
    logic [CNT_W-1:0]       lane_cnt;
    logic [CRC_W-1:0]       crc_base;
    logic [CRC_W-1:0]       crc_next;
    logic [CRC_W-1:0]       crc_refl;
    logic [CRC_W-1:0]       crc_final;

    // A pending result blocks input only while its consumer stalls.
    assign s_ready = !crc_valid || crc_ready;
    assign accept  = s_valid && s_ready;

    // Count leading contiguous keep bits and flag any set bit after the first gap.
    always_comb begin
        keep_shift = s_keep;
        keep_run   = 1'b1;
        keep_gap   = 1'b0;
        keep_cnt   = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (keep_shift[0]) begin
                if (keep_run) begin
                    keep_cnt = keep_cnt + CNT_W'(1);
                end else begin
                    keep_gap = 1'b1;
                end
            end else begin
                keep_run = 1'b0;
            end
            keep_shift = keep_shift >> 1;
        end
    end

    assign lane_cnt = s_eof ? keep_cnt : CNT_W'(DATA_BYTES);
    assign crc_base = s_sof ? CRC_W'(INIT) : crc_reg;

    crc_lane_chain #(
        .DATA_BYTES (DATA_BYTES),
        .CRC_W      (CRC_W),
        .POLY       (POLY),
        .REFLECT_IN (REFLECT_IN),
        .CNT_W      (CNT_W)
    ) u_chain (
        .crc_in (crc_base),
        .data   (s_data),
        .count  (lane_cnt),
        .crc_c  (crc_next)
    );

    // Output transform of the post-beat register.
    always_comb begin
        crc_refl  = {<<{crc_next}};
        crc_final = (REFLECT_OUT ? crc_refl : crc_next) ^ CRC_W'(XOR_OUT);
    end

    // Frame FSM, running register and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            crc_reg   <= CRC_W'(INIT);
            crc_valid <= 1'b0;
            crc_out   <= '0;
            crc_ok    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (crc_valid && crc_ready) begin
                crc_valid <= 1'b0;
            end
            if (accept) begin
                if ((state == S_IDLE) && !s_sof) begin
                    err_pulse <= 1'b1;
                end else begin
                    if ((state == S_ACTIVE) && s_sof) begin
                        err_pulse <= 1'b1;
                    end
                    if (s_eof && keep_gap) begin
                        err_pulse <= 1'b1;
                    end
                    if (s_eof) begin
                        crc_valid <= 1'b1;
                        crc_out   <= crc_final;
                        crc_ok    <= (crc_next == CRC_W'(RESIDUE));
                        crc_reg   <= CRC_W'(INIT);
                        state     <= S_IDLE;
                    end else begin
                        crc_reg   <= crc_next;
                        state     <= S_ACTIVE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream against a byte-level CRC model.
module tb_crc_stream;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;

    logic        s_valid, s_ready, s_sof, s_eof;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic [31:0] crc_out;
    logic        crc_ok, crc_valid, crc_ready, err_pulse;

    logic        t_valid, t_ready, t_sof, t_eof;
    logic [7:0]  t_data;
    logic [0:0]  t_keep;
    logic [15:0] t_crc;
    logic        t_ok, t_cvalid, t_cready, t_err;

    int          n_tests;
    int          n_fail;
    int          err_cnt;
    bit          rand_ready;
    logic [31:0] res_crc_q[$];
    logic        res_ok_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    crc_stream #(
        .DATA_BYTES(4), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .RESIDUE(32'hC704DD7B)
    ) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_keep(s_keep), .s_sof(s_sof), .s_eof(s_eof), .crc_out(crc_out), .crc_ok(crc_ok),
        .crc_valid(crc_valid), .crc_ready(crc_ready), .err_pulse(err_pulse)
    );

    crc_stream #(
        .DATA_BYTES(1), .CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF),
        .XOR_OUT(32'h0), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(32'h0)
    ) u_dut16 (
        .clk(clk), .rst(rst), .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data),
        .s_keep(t_keep), .s_sof(t_sof), .s_eof(t_eof), .crc_out(t_crc), .crc_ok(t_ok),
        .crc_valid(t_cvalid), .crc_ready(t_cready), .err_pulse(t_err)
    );

    // Record every consumed result and every error pulse.
    always @(negedge clk) begin
        if (!rst && crc_valid && crc_ready) begin
            res_crc_q.push_back(crc_out);
            res_ok_q.push_back(crc_ok);
        end
        if (!rst && err_pulse) err_cnt++;
    end

    // Random consumer stalls while enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            crc_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reflected (LSB-first) CRC-32 register; reflected poly of 04C11DB7 is EDB88320.
    function automatic logic [31:0] model_reg32(input bq_t q);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            r = r ^ {24'd0, q[i]};
            repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] model_crc32(input bq_t q);
        return model_reg32(q) ^ 32'hFFFF_FFFF;
    endfunction

    // Good-frame residue seen from the reflected side is bit-reversed C704DD7B.
    function automatic logic model_ok32(input bq_t q);
        return model_reg32(q) == 32'hDEBB_20E3;
    endfunction

    function automatic logic [15:0] model_crc16(input bq_t q);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (q[i]) begin
            r = r ^ {q[i], 8'h00};
            repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic bq_t check_str();
        bq_t q;
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        return q;
    endfunction

    function automatic logic [31:0] pack_beat(input bq_t q, input int pos, input int n);
        logic [31:0] d;
        d = $urandom;
        for (int l = 0; l < 4; l++) if (l < n) d[8*l +: 8] = q[pos+l];
        return d;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input logic sof, input logic eof);
        int guard;
        s_valid = 1'b1; s_data = d; s_keep = k; s_sof = sof; s_eof = eof;
        guard = 0;
        @(negedge clk);
        while (!s_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_tests++; n_fail++;
            $display("FAIL send_beat_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    endtask

    task automatic send_frame(input bq_t q, input bit extra);
        int rem, pos;
        logic sof;
        rem = q.size(); pos = 0; sof = 1'b1;
        while (rem > 4 || (rem == 4 && extra)) begin
            send_beat(pack_beat(q, pos, 4), 4'($urandom), sof, 1'b0);
            pos += 4; rem -= 4; sof = 1'b0;
        end
        send_beat(pack_beat(q, pos, rem), 4'((1 << rem) - 1), sof, 1'b1);
    endtask

    task automatic get_result(output logic [31:0] c, output logic ok, output bit got);
        int guard;
        guard = 0;
        while (res_crc_q.size() == 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        got = (res_crc_q.size() != 0);
        if (got) begin
            c  = res_crc_q.pop_front();
            ok = res_ok_q.pop_front();
        end else begin
            c = 'x; ok = 1'bx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_sof = 1'b0; s_eof = 1'b0;
        crc_ready = 1'b1;
        t_valid = 1'b0; t_data = '0; t_keep = 1'b1; t_sof = 1'b0; t_eof = 1'b0; t_cready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (crc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", crc_valid); end
        n_tests++; if (crc_out !== 32'h0) begin n_fail++; $display("FAIL reset_crc_out: got %h expected 0", crc_out); end
        n_tests++; if (crc_ok !== 1'b0) begin n_fail++; $display("FAIL reset_crc_ok: got %b expected 0", crc_ok); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_pulse); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_tests++; if (t_cvalid !== 1'b0 || t_crc !== 16'h0) begin n_fail++; $display("FAIL reset_crc16: valid %b crc %h expected 0 0000", t_cvalid, t_crc); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_check_string();
        bq_t q;
        logic [31:0] c; logic ok; bit got;
        q = check_str();
        send_frame(q, 1'b0);
        @(negedge clk);
        n_tests++; if (crc_valid !== 1'b1) begin n_fail++; $display("FAIL check_latency: crc_valid %b expected 1", crc_valid); end
        n_tests++; if (crc_out !== 32'hCBF43926) begin n_fail++; $display("FAIL check_value: got %h expected cbf43926", crc_out); end
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(q)) begin n_fail++; $display("FAIL check_result: got %h expected %h", c, model_crc32(q)); end
        n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL check_ok: got %b expected 0", ok); end
    endtask

    task automatic test_residue();
        bq_t q;
        logic [31:0] c; logic ok; bit got;
        q = check_str();
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send_frame(q, 1'b0);
        get_result(c, ok, got);
        n_tests++; if (!got || ok !== 1'b1) begin n_fail++; $display("FAIL residue_good: got %b expected 1", ok); end
        n_tests++; if (c !== model_crc32(q)) begin n_fail++; $display("FAIL residue_crc: got %h expected %h", c, model_crc32(q)); end
        q[3] = q[3] ^ 8'h04;
        send_frame(q, 1'b0);
        get_result(c, ok, got);
        n_tests++; if (!got || ok !== 1'b0) begin n_fail++; $display("FAIL residue_bad: got %b expected 0", ok); end
    endtask

    task automatic test_single_zero();
        bq_t q;
        logic [31:0] c; logic ok; bit got;
        q.push_back(8'h00);
        send_frame(q, 1'b0);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== 32'hD202EF8D) begin n_fail++; $display("FAIL single_zero: got %h expected d202ef8d", c); end
    endtask

    task automatic test_keep_edges();
        bq_t q, q1, qe;
        logic [31:0] c, d; logic ok; bit got;
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        send_frame(q, 1'b1);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(q)) begin n_fail++; $display("FAIL keep_zero_eof: got %h expected %h", c, model_crc32(q)); end
        send_frame(qe, 1'b0);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(qe)) begin n_fail++; $display("FAIL empty_frame: got %h expected %h", c, model_crc32(qe)); end
        d = $urandom;
        q1.push_back(d[7:0]);
        send_beat(d, 4'b1101, 1'b1, 1'b1);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(q1)) begin n_fail++; $display("FAIL keep_gap_lane0: got %h expected %h", c, model_crc32(q1)); end
        send_beat($urandom, 4'b0110, 1'b1, 1'b1);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(qe)) begin n_fail++; $display("FAIL keep_gap_none: got %h expected %h", c, model_crc32(qe)); end
        n_tests++; if (err_cnt !== e0 + 2) begin n_fail++; $display("FAIL keep_gap_err: got %0d expected %0d", err_cnt - e0, 2); end
    endtask

    task automatic test_errors();
        bq_t qy;
        logic [31:0] c; logic ok; bit got;
        int e0;
        e0 = err_cnt;
        send_beat($urandom, 4'hF, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        n_tests++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL err_no_sof: got %0d pulses expected 1", err_cnt - e0); end
        n_tests++; if (res_crc_q.size() != 0) begin n_fail++; $display("FAIL err_no_sof_result: got %0d results expected 0", res_crc_q.size()); end
        send_beat($urandom, 4'hF, 1'b1, 1'b0);
        send_beat($urandom, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) qy.push_back(8'($urandom));
        send_frame(qy, 1'b0);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(qy)) begin n_fail++; $display("FAIL err_abort_crc: got %h expected %h", c, model_crc32(qy)); end
        n_tests++; if (err_cnt !== e0 + 2) begin n_fail++; $display("FAIL err_abort_pulse: got %0d pulses expected 2", err_cnt - e0); end
        n_tests++; if (res_crc_q.size() != 0) begin n_fail++; $display("FAIL err_abort_extra: got %0d extra results expected 0", res_crc_q.size()); end
    endtask

    task automatic test_backpressure();
        bq_t qa, qb;
        logic [31:0] c, exp_a; logic ok; bit got;
        for (int i = 0; i < 6; i++) qa.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) qb.push_back(8'($urandom));
        exp_a = model_crc32(qa);
        crc_ready = 1'b0;
        send_frame(qa, 1'b0);
        fork
            send_frame(qb, 1'b0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b expected 0", s_ready); end
                    n_tests++; if (crc_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", crc_valid); end
                    n_tests++; if (crc_out !== exp_a) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", crc_out, exp_a); end
                end
                @(posedge clk);
                #1;
                crc_ready = 1'b1;
            end
        join
        get_result(c, ok, got);
        n_tests++; if (!got || c !== exp_a) begin n_fail++; $display("FAIL bp_first: got %h expected %h", c, exp_a); end
        get_result(c, ok, got);
        n_tests++; if (!got || c !== model_crc32(qb)) begin n_fail++; $display("FAIL bp_second: got %h expected %h", c, model_crc32(qb)); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] c; logic ok; bit got;
        int e0;
        send_beat($urandom, 4'hF, 1'b1, 1'b0);
        send_beat($urandom, 4'hF, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e0 = err_cnt;
        @(negedge clk);
        n_tests++; if (crc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", crc_valid); end
        @(posedge clk);
        #1;
        send_frame(check_str(), 1'b0);
        get_result(c, ok, got);
        n_tests++; if (!got || c !== 32'hCBF43926) begin n_fail++; $display("FAIL rst_mid_crc: got %h expected cbf43926", c); end
        n_tests++; if (err_cnt !== e0 || res_crc_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_clean: got %0d errors %0d extra expected 0 0", err_cnt - e0, res_crc_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_c[$];
        logic [31:0] c; logic ok; bit got;
        bq_t q;
        int e0;
        e0 = err_cnt;
        for (int f = 0; f < 8; f++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) q.push_back(8'($urandom));
            exp_c.push_back(model_crc32(q));
            send_frame(q, 1'b0);
        end
        foreach (exp_c[f]) begin
            get_result(c, ok, got);
            n_tests++; if (!got || c !== exp_c[f]) begin n_fail++; $display("FAIL b2b_frame%0d: got %h expected %h", f, c, exp_c[f]); end
        end
        n_tests++; if (err_cnt !== e0) begin n_fail++; $display("FAIL b2b_err: got %0d pulses expected 0", err_cnt - e0); end
    endtask

    task automatic test_random();
        logic [31:0] exp_c[$];
        logic        exp_o[$];
        logic [31:0] c, fcs; logic ok; bit got;
        bq_t q;
        int e0, n;
        e0 = err_cnt;
        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            q = {};
            n = $urandom_range(0, 14);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                fcs = model_crc32(q);
                q.push_back(fcs[7:0]); q.push_back(fcs[15:8]);
                q.push_back(fcs[23:16]); q.push_back(fcs[31:24]);
            end
            exp_c.push_back(model_crc32(q));
            exp_o.push_back(model_ok32(q));
            send_frame(q, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        crc_ready = 1'b1;
        foreach (exp_c[f]) begin
            get_result(c, ok, got);
            n_tests++; if (!got || c !== exp_c[f]) begin n_fail++; $display("FAIL rand_crc%0d: got %h expected %h", f, c, exp_c[f]); end
            n_tests++; if (ok !== exp_o[f]) begin n_fail++; $display("FAIL rand_ok%0d: got %b expected %b", f, ok, exp_o[f]); end
        end
        n_tests++; if (err_cnt !== e0 || res_crc_q.size() != 0) begin n_fail++; $display("FAIL rand_clean: got %0d errors %0d extra expected 0 0", err_cnt - e0, res_crc_q.size()); end
    endtask

    task automatic test_crc16();
        bq_t q;
        logic [15:0] exp;
        q = check_str();
        for (int pass = 0; pass < 2; pass++) begin
            exp = model_crc16(q);
            for (int i = 0; i < q.size(); i++) begin
                t_valid = 1'b1; t_data = q[i]; t_keep = 1'b1;
                t_sof = (i == 0); t_eof = (i == q.size() - 1);
                @(posedge clk);
                #1;
            end
            t_valid = 1'b0; t_sof = 1'b0; t_eof = 1'b0;
            @(negedge clk);
            n_tests++; if (t_cvalid !== 1'b1) begin n_fail++; $display("FAIL crc16_valid%0d: got %b expected 1", pass, t_cvalid); end
            if (pass == 0) begin
                n_tests++; if (t_crc !== 16'h29B1) begin n_fail++; $display("FAIL crc16_value: got %h expected 29b1", t_crc); end
                n_tests++; if (t_ok !== 1'b0) begin n_fail++; $display("FAIL crc16_ok_data: got %b expected 0", t_ok); end
            end else begin
                n_tests++; if (t_crc !== exp) begin n_fail++; $display("FAIL crc16_fcs_value: got %h expected %h", t_crc, exp); end
                n_tests++; if (t_ok !== 1'b1) begin n_fail++; $display("FAIL crc16_ok_fcs: got %b expected 1", t_ok); end
            end
            @(posedge clk);
            #1;
            q.push_back(exp[15:8]);
            q.push_back(exp[7:0]);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; err_cnt = 0; rand_ready = 1'b0;
        test_reset();
        test_check_string();
        test_residue();
        test_single_zero();
        test_keep_edges();
        test_errors();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_crc16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
